// File: rtl/router_fsm_param_pkg.sv
// router_fsm_param_pkg: state encodings and drop-cause codes shared by the router control FSM.
package router_fsm_param_pkg;
  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    LOAD_PARITY        = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    WAIT_TILL_EMPTY    = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;
  typedef enum logic [1:0] {
    DROP_NONE     = 2'b00,
    DROP_BAD_ADDR = 2'b01,
    DROP_TIMEOUT  = 2'b10
  } drop_cause_t;
endpackage

// File: rtl/router_fsm_param_if.sv
// router_fsm_param_if: control/status bundle between the router datapath and its control FSM.
interface router_fsm_param_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2
);
  logic                 pkt_valid;
  logic [ADDR_W-1:0]    data_in;
  logic                 parity_done;
  logic                 low_pkt_valid;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 rst_int_reg;
  logic                 drop_state;
  logic                 write_enb_reg;
  logic                 busy;
  logic [ADDR_W-1:0]    dest_sel;
  logic [1:0]           drop_cause;
  modport master (
    output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, soft_reset,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, drop_state,
           write_enb_reg, busy, dest_sel, drop_cause
  );
  modport slave (
    input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, soft_reset,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, drop_state,
           write_enb_reg, busy, dest_sel, drop_cause
  );
endinterface

// File: rtl/router_fsm_param_wait_timer.sv
// router_wait_timer: counts cycles spent waiting for the destination FIFO; expire flags the last allowed cycle.
module router_wait_timer #(
  parameter int LIMIT = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic expire
);
  localparam int W = LIMIT > 0 ? $clog2(LIMIT + 1) : 1;
  logic [W-1:0] r_cnt;
  always_ff @(posedge clock)
    r_cnt <= (reset || !run || LIMIT == 0) ? '0 : r_cnt + 1'b1;
  assign expire = (LIMIT != 0) && (r_cnt == W'(LIMIT - 1));
endmodule

// File: rtl/router_fsm_param.sv
// router_fsm_param: packet-router control FSM with address decode, FIFO-full stall, wait timeout and drop handling.
module router_fsm_param
  import router_fsm_param_pkg::*;
#(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_W     = 2,
  parameter int WAIT_LIMIT = 32
) (
  input logic clock,
  input logic reset,
  router_fsm_param_if.slave bus
);
  localparam int NA = 2 ** ADDR_W;
  state_t            r_state, w_next;
  drop_cause_t       r_drop_cause;
  logic [ADDR_W-1:0] r_dest_sel;
  logic [NA-1:0]     w_empty, w_soft;
  logic              w_valid_addr, w_expire, w_soft_hit;
  // Widen per-port flags to the full address space so any address indexes safely.
  assign w_empty      = NA'(bus.fifo_empty);
  assign w_soft       = NA'(bus.soft_reset);
  assign w_valid_addr = 32'(bus.data_in) < NUM_PORTS;
  assign w_soft_hit   = w_soft[r_dest_sel] && r_state != DECODE_ADDRESS && r_state != DROP_PACKET;
  router_wait_timer #(.LIMIT(WAIT_LIMIT)) u_timer (
    .clock (clock),
    .reset (reset),
    .run   (r_state == WAIT_TILL_EMPTY),
    .expire(w_expire)
  );
  always_comb begin
    w_next = DECODE_ADDRESS;
    case (r_state)
      DECODE_ADDRESS:     w_next = !bus.pkt_valid ? DECODE_ADDRESS :
                                   !w_valid_addr ? DROP_PACKET :
                                   w_empty[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    w_next = LOAD_DATA;
      LOAD_DATA:          w_next = bus.fifo_full ? FIFO_FULL_STATE : !bus.pkt_valid ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: w_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      FIFO_FULL_STATE:    w_next = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    w_next = bus.parity_done ? DECODE_ADDRESS : bus.low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
      WAIT_TILL_EMPTY:    w_next = w_empty[r_dest_sel] ? LOAD_FIRST_DATA : w_expire ? DROP_PACKET : WAIT_TILL_EMPTY;
      DROP_PACKET:        w_next = bus.pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
      default:            w_next = DECODE_ADDRESS;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= DECODE_ADDRESS;
      r_dest_sel   <= '0;
      r_drop_cause <= DROP_NONE;
    end else begin
      r_state <= w_soft_hit ? DECODE_ADDRESS : w_next;
      if (r_state == DECODE_ADDRESS && bus.pkt_valid) r_dest_sel <= bus.data_in;
      if (!w_soft_hit && w_next == DROP_PACKET && r_state != DROP_PACKET)
        r_drop_cause <= r_state == WAIT_TILL_EMPTY ? DROP_TIMEOUT : DROP_BAD_ADDR;
    end
  end
  assign bus.detect_add    = r_state == DECODE_ADDRESS;
  assign bus.lfd_state     = r_state == LOAD_FIRST_DATA;
  assign bus.ld_state      = r_state == LOAD_DATA;
  assign bus.laf_state     = r_state == LOAD_AFTER_FULL;
  assign bus.full_state    = r_state == FIFO_FULL_STATE;
  assign bus.rst_int_reg   = r_state == CHECK_PARITY_ERROR;
  assign bus.drop_state    = r_state == DROP_PACKET;
  assign bus.write_enb_reg = r_state == LOAD_DATA || r_state == LOAD_AFTER_FULL || r_state == LOAD_PARITY;
  assign bus.busy          = r_state == LOAD_FIRST_DATA || r_state == LOAD_PARITY || r_state == FIFO_FULL_STATE ||
                             r_state == LOAD_AFTER_FULL || r_state == CHECK_PARITY_ERROR || r_state == WAIT_TILL_EMPTY;
  assign bus.dest_sel      = r_dest_sel;
  assign bus.drop_cause    = r_drop_cause;
endmodule

// File: tb/tb_router_fsm_param.sv
// tb_router_fsm_param: directed scenarios for the router control FSM with hand-derived state sequences.
module tb_router_fsm_param;
  localparam int DEC = 0, LFD = 1, LD = 2, LP = 3, FULL = 4, LAF = 5, WT = 6, CPE = 7, DROP = 8;
  logic clock = 0;
  logic reset = 1;
  int   checks = 0;
  int   errors = 0;
  router_fsm_param_if #(.NUM_PORTS(3), .ADDR_W(2)) bus ();
  router_fsm_param #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_LIMIT(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );
  always #5 clock = ~clock;
  function automatic logic [8:0] eo(input int s);
    case (s)
      DEC:     return 9'b100000000;
      LFD:     return 9'b010000001;
      LD:      return 9'b001000010;
      LP:      return 9'b000000011;
      FULL:    return 9'b000010001;
      LAF:     return 9'b000100011;
      WT:      return 9'b000000001;
      CPE:     return 9'b000001001;
      DROP:    return 9'b000000100;
      default: return 9'b000000000;
    endcase
  endfunction
  function automatic logic [8:0] obs();
    return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
            bus.rst_int_reg, bus.drop_state, bus.write_enb_reg, bus.busy};
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    bus.pkt_valid = 0; bus.data_in = 0; bus.parity_done = 0; bus.low_pkt_valid = 0;
    bus.fifo_full = 0; bus.fifo_empty = 3'b111; bus.soft_reset = 0;
  endtask
  task automatic test_reset();
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    checks++;
    if (obs() !== eo(DEC)) begin errors++; $display("FAIL reset_outs: got %b expected %b", obs(), eo(DEC)); end
    checks++;
    if (bus.dest_sel !== 2'd0) begin errors++; $display("FAIL reset_dest_sel: got %0d expected 0", bus.dest_sel); end
    checks++;
    if (bus.drop_cause !== 2'b00) begin errors++; $display("FAIL reset_drop_cause: got %b expected 00", bus.drop_cause); end
  endtask
  task automatic test_basic_packet();
    int pv [8];
    int ex [8];
    int wen = 0;
    pv = '{1, 1, 1, 1, 1, 0, 0, 0};
    ex = '{LFD, LD, LD, LD, LD, LP, CPE, DEC};
    idle();
    bus.data_in = 2'd1;
    for (int i = 0; i < 8; i++) begin
      bus.pkt_valid = pv[i][0];
      tick();
      wen += int'(bus.write_enb_reg);
      checks++;
      if (obs() !== eo(ex[i])) begin errors++; $display("FAIL basic_state[%0d]: got %b expected %b", i, obs(), eo(ex[i])); end
    end
    checks++;
    if (wen != 5) begin errors++; $display("FAIL basic_write_cycles: got %0d expected 5", wen); end
    checks++;
    if (bus.dest_sel !== 2'd1) begin errors++; $display("FAIL basic_dest_sel: got %0d expected 1", bus.dest_sel); end
  endtask
  task automatic test_bad_address();
    idle();
    bus.data_in = 2'd3;
    bus.pkt_valid = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs() !== eo(DROP)) begin errors++; $display("FAIL badaddr_state[%0d]: got %b expected %b", i, obs(), eo(DROP)); end
    end
    checks++;
    if (bus.drop_cause !== 2'b01) begin errors++; $display("FAIL badaddr_cause: got %b expected 01", bus.drop_cause); end
    bus.pkt_valid = 0;
    tick();
    checks++;
    if (obs() !== eo(DEC)) begin errors++; $display("FAIL badaddr_return: got %b expected %b", obs(), eo(DEC)); end
  endtask
  task automatic test_wait_timeout();
    int ex [6];
    ex = '{WT, WT, WT, WT, DROP, DEC};
    idle();
    bus.data_in = 2'd0;
    bus.fifo_empty = 3'b110;
    for (int i = 0; i < 6; i++) begin
      bus.pkt_valid = (i < 5);
      tick();
      checks++;
      if (obs() !== eo(ex[i])) begin errors++; $display("FAIL timeout_state[%0d]: got %b expected %b", i, obs(), eo(ex[i])); end
    end
    checks++;
    if (bus.drop_cause !== 2'b10) begin errors++; $display("FAIL timeout_cause: got %b expected 10", bus.drop_cause); end
  endtask
  task automatic test_wait_release();
    int ex [9];
    ex = '{WT, WT, WT, WT, LFD, LD, LP, CPE, DEC};
    idle();
    bus.data_in = 2'd0;
    for (int i = 0; i < 9; i++) begin
      bus.fifo_empty = (i < 4) ? 3'b110 : 3'b111;
      bus.pkt_valid = (i < 6);
      tick();
      checks++;
      if (obs() !== eo(ex[i])) begin errors++; $display("FAIL release_state[%0d]: got %b expected %b", i, obs(), eo(ex[i])); end
    end
    checks++;
    if (bus.drop_cause !== 2'b10) begin errors++; $display("FAIL release_cause: got %b expected 10", bus.drop_cause); end
  endtask
  task automatic test_fifo_full();
    logic [3:0] vec [14];
    int ex [14];
    vec = '{4'b1000, 4'b1000, 4'b0100, 4'b1100, 4'b1100, 4'b1000, 4'b1000,
            4'b1100, 4'b1000, 4'b1010, 4'b1100, 4'b1100, 4'b1000, 4'b1011};
    ex  = '{LFD, LD, FULL, FULL, FULL, LAF, LD, FULL, LAF, LP, CPE, FULL, LAF, DEC};
    idle();
    bus.data_in = 2'd2;
    for (int i = 0; i < 14; i++) begin
      {bus.pkt_valid, bus.fifo_full, bus.low_pkt_valid, bus.parity_done} = vec[i];
      tick();
      checks++;
      if (obs() !== eo(ex[i])) begin errors++; $display("FAIL full_state[%0d]: got %b expected %b", i, obs(), eo(ex[i])); end
    end
    idle();
  endtask
  task automatic test_soft_reset();
    int ex [5];
    idle();
    bus.data_in = 2'd2;
    bus.pkt_valid = 1;
    tick(); tick();
    bus.soft_reset = 3'b100;
    tick();
    bus.soft_reset = 0;
    bus.pkt_valid = 0;
    checks++;
    if (obs() !== eo(DEC)) begin errors++; $display("FAIL soft_hit: got %b expected %b", obs(), eo(DEC)); end
    tick();
    ex = '{LFD, LD, LD, LP, CPE};
    bus.data_in = 2'd1;
    for (int i = 0; i < 5; i++) begin
      bus.pkt_valid = (i < 3);
      bus.soft_reset = (i == 2) ? 3'b100 : 3'b000;
      tick();
      checks++;
      if (obs() !== eo(ex[i])) begin errors++; $display("FAIL soft_miss[%0d]: got %b expected %b", i, obs(), eo(ex[i])); end
    end
    bus.soft_reset = 0;
    tick();
    bus.data_in = 2'd3;
    bus.pkt_valid = 1;
    tick();
    bus.soft_reset = 3'b111;
    tick();
    checks++;
    if (obs() !== eo(DROP)) begin errors++; $display("FAIL soft_in_drop: got %b expected %b", obs(), eo(DROP)); end
    idle();
    tick();
    bus.data_in = 2'd2;
    bus.pkt_valid = 1;
    tick(); tick();
    bus.fifo_full = 1;
    tick();
    checks++;
    if (obs() !== eo(FULL)) begin errors++; $display("FAIL pre_reset_full: got %b expected %b", obs(), eo(FULL)); end
    reset = 1;
    tick();
    reset = 0;
    idle();
    checks++;
    if (obs() !== eo(DEC)) begin errors++; $display("FAIL midfull_reset_outs: got %b expected %b", obs(), eo(DEC)); end
    checks++;
    if (bus.dest_sel !== 2'd0 || bus.drop_cause !== 2'b00) begin
      errors++; $display("FAIL midfull_reset_regs: got dest_sel=%0d cause=%b expected 0/00", bus.dest_sel, bus.drop_cause);
    end
  endtask
  initial begin
    test_reset();
    test_basic_packet();
    test_bad_address();
    test_wait_timeout();
    test_wait_release();
    test_fifo_full();
    test_soft_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
